// File: rtl/seg_level_rx.sv
// seg_level_rx: debounced 7-segment humidity-level receiver.
// Synchronizes the segment lines, waits for a stable pattern, then decodes it
// into a 2-bit level code with update pulse, error flag and saturating error count.
module seg_level_rx #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             e,
    input  logic             f,
    input  logic             g,
    output logic [1:0]       level,
    output logic             valid,
    output logic             upd,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned SEG_W = 7;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [SEG_W-1:0] PAT_L0 = 7'b0000000;
    localparam logic [SEG_W-1:0] PAT_L1 = 7'b1111110;
    localparam logic [SEG_W-1:0] PAT_L2 = 7'b0110000;
    localparam logic [SEG_W-1:0] PAT_L3 = 7'b1101101;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t           state;
    logic [SEG_W-1:0] p_raw;
    logic [SEG_W-1:0] sync1;
    logic [SEG_W-1:0] ps;
    logic [1:0]       warm;
    logic [SEG_W-1:0] cand;
    logic             cand_vld;
    logic [CNT_W-1:0] cnt;
    logic             done;
    logic             commit_c;
    logic [1:0]       code_c;
    logic             legal_c;

    assign p_raw = {a, b, c, d, e, f, g};

    // Two-flop synchronizer; warm marks when ps holds a real sample rather than reset zeros
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            ps    <= '0;
            warm  <= '0;
        end else begin
            sync1 <= p_raw;
            ps    <= sync1;
            warm  <= {warm[0], 1'b1};
        end
    end

    // Candidate tracking: a new pattern restarts the count, a repeated one advances it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand     <= '0;
            cand_vld <= 1'b0;
            cnt      <= '0;
            done     <= 1'b0;
        end else if (warm[1]) begin
            if (!cand_vld || (ps != cand)) begin
                cand     <= ps;
                cand_vld <= 1'b1;
                cnt      <= '0;
                done     <= 1'b0;
            end else begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (cnt == CNT_MAX) begin
                    done <= 1'b1;
                end
            end
        end
    end

    // One commit per stable run, on the edge that sees the count already at its limit
    assign commit_c = warm[1] && cand_vld && (ps == cand) && (cnt == CNT_MAX) && !done;

    // Segment pattern to level code; anything outside the table is illegal
    always_comb begin
        code_c  = 2'd0;
        legal_c = 1'b1;
        case (cand)
            PAT_L0:  code_c = 2'd0;
            PAT_L1:  code_c = 2'd1;
            PAT_L2:  code_c = 2'd2;
            PAT_L3:  code_c = 2'd3;
            default: legal_c = 1'b0;
        endcase
    end

    // Commit FSM with registered level/valid/upd/err/err_cnt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= WAIT;
            level   <= 2'd0;
            valid   <= 1'b0;
            upd     <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            upd <= 1'b0;
            if (commit_c) begin
                if (legal_c) begin
                    level <= code_c;
                    valid <= 1'b1;
                    err   <= 1'b0;
                    upd   <= (state != LOCKED) || (code_c != level);
                    state <= LOCKED;
                end else begin
                    valid <= 1'b0;
                    err   <= 1'b1;
                    if (err_cnt != {ERR_W{1'b1}}) begin
                        err_cnt <= err_cnt + ERR_W'(1);
                    end
                    state <= FAULT;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_level_rx.sv
// tb_seg_level_rx: scoreboard bench for seg_level_rx.
// Stimulus feeds a pattern-level model that queues expected output changes with
// the edge on which they must appear; a negedge monitor pops and compares.
module tb_seg_level_rx;

    localparam int S     = 4;
    localparam int ERR_W = 8;

    localparam logic [6:0] P0   = 7'b0000000;
    localparam logic [6:0] P1   = 7'b1111110;
    localparam logic [6:0] P2   = 7'b0110000;
    localparam logic [6:0] P3   = 7'b1101101;
    localparam logic [6:0] PBAD = 7'b1111111;
    localparam logic [6:0] PBD2 = 7'b0000001;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0, f = 1'b0, g = 1'b0;
    logic [1:0]       level;
    logic             valid;
    logic             upd;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    seg_level_rx #(.STABLE_CYCLES(S), .ERR_W(ERR_W)) dut (
        .clk(clk), .reset(reset),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .level(level), .valid(valid), .upd(upd), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at_edge;
        logic [1:0] level;
        logic       valid;
        logic       upd;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // model state: 0 = WAIT, 1 = LOCKED, 2 = FAULT
    int         m_state = 0;
    logic [1:0] m_level = 2'd0;
    logic       m_valid = 1'b0;
    logic       m_err = 1'b0;
    logic [7:0] m_cnt = 8'd0;
    logic [6:0] run_pat = 7'd0;
    int         run_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic model_clear();
        m_state = 0; m_level = 2'd0; m_valid = 1'b0; m_err = 1'b0; m_cnt = 8'd0;
        run_len = 0;
        q.delete();
    endtask

    // Called once per rising edge with the pattern that edge samples
    task automatic model_sample(input logic [6:0] p, input int edge_now);
        exp_t       x;
        logic [1:0] code;
        logic       legal;
        logic       u;
        logic [1:0] ol;
        logic       ov, oe;
        logic [7:0] oc;
        if (run_len == 0 || p != run_pat) begin
            run_pat = p;
            run_len = 1;
        end else if (run_len <= S + 1) begin
            run_len++;
        end
        if (run_len == S + 1) begin
            ol = m_level; ov = m_valid; oe = m_err; oc = m_cnt;
            legal = 1'b1; code = 2'd0; u = 1'b0;
            case (p)
                P0: code = 2'd0;
                P1: code = 2'd1;
                P2: code = 2'd2;
                P3: code = 2'd3;
                default: legal = 1'b0;
            endcase
            if (legal) begin
                u = (m_state != 1) || (code != m_level);
                m_level = code; m_valid = 1'b1; m_err = 1'b0; m_state = 1;
            end else begin
                m_valid = 1'b0; m_err = 1'b1; m_state = 2;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end
            if (u || ol != m_level || ov != m_valid || oe != m_err || oc != m_cnt) begin
                x.at_edge = edge_now + 2;
                x.level = m_level; x.valid = m_valid; x.upd = u; x.err = m_err; x.cnt = m_cnt;
                q.push_back(x);
            end
        end
    endtask

    // Apply pattern p at a falling edge and hold it for n rising edges
    task automatic drive(input logic [6:0] p, input int n);
        @(negedge clk);
        {a, b, c, d, e, f, g} = p;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_sample(p, cyc + 1);
        end
    endtask

    // Monitor: any output change or upd high must match the head of the queue
    logic [11:0] prev = '0;
    always @(negedge clk) begin
        exp_t x;
        if (reset) begin
            prev = '0;
        end else begin
            if (q.size() > 0 && q[0].at_edge < cyc) begin
                checks++;
                failures++;
                x = q.pop_front();
                $display("FAIL missing_update: nothing seen, expected at edge %0d level=%0d", x.at_edge, x.level);
            end
            if ({level, valid, err, err_cnt} != prev || upd) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: edge %0d got level=%0d valid=%0b upd=%0b err=%0b cnt=%0d expected no change",
                             cyc, level, valid, upd, err, err_cnt);
                end else begin
                    x = q.pop_front();
                    if (x.at_edge != cyc || x.level != level || x.valid != valid || x.upd != upd ||
                        x.err != err || x.cnt != err_cnt) begin
                        failures++;
                        $display("FAIL commit_output: got edge=%0d level=%0d valid=%0b upd=%0b err=%0b cnt=%0d expected edge=%0d level=%0d valid=%0b upd=%0b err=%0b cnt=%0d",
                                 cyc, level, valid, upd, err, err_cnt,
                                 x.at_edge, x.level, x.valid, x.upd, x.err, x.cnt);
                    end
                end
            end
            prev = {level, valid, err, err_cnt};
        end
    end

    initial begin
        logic [6:0] pats [4];
        logic [6:0] last;
        pats[0] = P0; pats[1] = P1; pats[2] = P2; pats[3] = P3;

        // reset state
        #1;
        chk("reset_level", int'(level), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_err_cnt", int'(err_cnt), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        model_clear();

        // first legal code: commit on edge 7 after release, upd pulse
        drive(P3, 10);
        chk("locked_level", int'(level), 3);
        chk("locked_valid_noerr", int'({valid, err}), 2);

        // short glitch ignored, return to same code gives no upd
        drive(P2, 3);
        drive(P3, 10);
        chk("glitch_level", int'(level), 3);

        // illegal commit then recovery
        drive(PBAD, 8);
        chk("fault_err", int'(err), 1);
        chk("fault_valid", int'(valid), 0);
        chk("fault_level_held", int'(level), 3);
        chk("fault_err_cnt", int'(err_cnt), 1);
        drive(P1, 8);
        chk("recover_level", int'(level), 1);
        chk("recover_err", int'(err), 0);

        // 300 illegal commits: counter saturates without wrapping
        for (int k = 0; k < 300; k++) begin
            drive((k % 2) ? PBD2 : PBAD, 5);
        end
        drive(PBD2, 3);
        chk("err_cnt_saturated", int'(err_cnt), 255);

        // async reset mid-count clears outputs at once
        drive(P2, 2);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_level", int'(level), 0);
        chk("async_rst_valid", int'(valid), 0);
        chk("async_rst_upd", int'(upd), 0);
        chk("async_rst_err", int'(err), 0);
        chk("async_rst_err_cnt", int'(err_cnt), 0);
        model_clear();
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        drive(P0, 10);
        chk("post_rst_level", int'(level), 0);
        chk("post_rst_valid", int'(valid), 1);

        // sweep of legal codes with varied hold times
        last = P0;
        for (int k = 0; k < 24; k++) begin
            last = pats[$urandom_range(0, 3)];
            drive(last, int'($urandom_range(4, 10)));
        end
        drive(last, 10);

        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got edge %0d expected finish", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
